// File: rtl/debounce_ctrl.sv
// Multi-channel debounce controller: one shared sample tick drives N_CH independent
// debounce FSMs, each producing a clean level plus single-cycle rise/fall pulses.
module debounce_ctrl #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_CYCLES  = 2000000,
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy,
  output logic            tick
);

  localparam int unsigned TickW = $clog2(TICK_CYCLES);
  localparam int unsigned CntW  = $clog2(STABLE_TICKS + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    StStableLo,
    StChkHi,
    StStableHi,
    StChkLo
  } state_e;

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [N_CH-1:0]  sync1_q, sync2_q;
  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [CntW-1:0]  cnt_q   [N_CH];
  logic [CntW-1:0]  cnt_d   [N_CH];
  logic [N_CH-1:0]  btn_db_q, btn_db_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;

  // Counter is held at zero while disabled so the tick phase restarts on resume.
  always_comb begin
    tick_cnt_d = '0;
    if (enable && (tick_cnt_q != TickLast)) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  assign tick = enable & (tick_cnt_q == TickLast);

  always_comb begin
    btn_db_d = btn_db_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A reverting input aborts the check before any tick is considered.
      unique case (state_q[i])
        StStableLo: begin
          if (sync2_q[i]) begin
            state_d[i] = StChkHi;
            cnt_d[i]   = '0;
          end
        end
        StChkHi: begin
          if (!sync2_q[i]) begin
            state_d[i] = StStableLo;
            cnt_d[i]   = '0;
          end else if (tick && (cnt_q[i] == CntLast)) begin
            state_d[i]  = StStableHi;
            cnt_d[i]    = '0;
            btn_db_d[i] = 1'b1;
            rise_d[i]   = 1'b1;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StStableHi: begin
          if (!sync2_q[i]) begin
            state_d[i] = StChkLo;
            cnt_d[i]   = '0;
          end
        end
        StChkLo: begin
          if (sync2_q[i]) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = '0;
          end else if (tick && (cnt_q[i] == CntLast)) begin
            state_d[i]  = StStableLo;
            cnt_d[i]    = '0;
            btn_db_d[i] = 1'b0;
            fall_d[i]   = 1'b1;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StStableLo;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      busy[i] = (state_q[i] == StChkHi) || (state_q[i] == StChkLo);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      btn_db_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= StStableLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      btn_db_q   <= btn_db_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_db = btn_db_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Scoreboard bench for debounce_ctrl: stimulus pushes expected pulses with their
// acceptance window; a negedge monitor pops and checks each pulse the DUT emits.
module tb_debounce_ctrl;

  localparam int unsigned NCh         = 4;
  localparam int unsigned TickCycles  = 4;
  localparam int unsigned StableTicks = 3;
  // Window after the btn_in change (2 sync flops + 1 FSM entry = 3 cycles).
  localparam int LoOff = 3 + (StableTicks - 1) * TickCycles + 1;
  localparam int HiOff = 3 + StableTicks * TickCycles;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [NCh-1:0] btn_in;
  logic [NCh-1:0] btn_db;
  logic [NCh-1:0] rise;
  logic [NCh-1:0] fall;
  logic [NCh-1:0] busy;
  logic           tick;

  debounce_ctrl #(
    .N_CH        (NCh),
    .TICK_CYCLES (TickCycles),
    .STABLE_TICKS(StableTicks)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .btn_in(btn_in),
    .btn_db(btn_db),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCh-1:0] rise;
    logic [NCh-1:0] fall;
    logic [NCh-1:0] db;
    int             lo;
    int             hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NCh-1:0] r, input logic [NCh-1:0] f,
                          input logic [NCh-1:0] db, input int lo, input int hi);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.db   = db;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT emits must match the oldest expectation.
  logic [NCh-1:0] prev_r = '0;
  logic [NCh-1:0] prev_f = '0;
  exp_t           mon_e;
  always @(negedge clk) begin
    if ((rise | fall) != '0) begin
      check(((rise & prev_r) | (fall & prev_f)) == '0, "pulse_width", {rise, fall},
            {prev_r, prev_f});
      check((rise & fall) == '0, "rise_fall_excl", {rise, fall}, 0);
      check(exp_q.size() != 0, "unexpected_pulse", {rise, fall}, 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check((rise == mon_e.rise) && (fall == mon_e.fall), "pulse_bits", {rise, fall},
              {mon_e.rise, mon_e.fall});
        check(btn_db == mon_e.db, "level", btn_db, mon_e.db);
        check((cyc >= mon_e.lo) && (cyc <= mon_e.hi), "window", cyc, mon_e.lo);
      end
    end
    prev_r = rise;
    prev_f = fall;
  end

  int  p;
  int  e_cyc;
  bit  found;
  bit  held_ok;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    btn_in = '0;
    #1;
    check({btn_db, rise, fall, busy, tick} == '0, "in_reset", {btn_db, rise, fall, busy, tick}, 0);
    step(3);
    reset = 1'b0;
    step(1);
    check({btn_db, rise, fall, busy, tick} == '0, "post_reset",
          {btn_db, rise, fall, busy, tick}, 0);

    // Channel 0 press.
    btn_in[0] = 1'b1;
    p = cyc;
    push_exp(4'b0001, 4'b0000, 4'b0001, p + LoOff, p + HiOff);
    step(2);
    check(busy == 4'b0000, "busy_before_entry", busy, 4'b0000);
    step(1);
    check(busy == 4'b0001, "busy_at_entry", busy, 4'b0001);
    step(21);
    check(btn_db == 4'b0001, "ch0_level_hi", btn_db, 4'b0001);
    check(busy == 4'b0000, "ch0_idle_hi", busy, 4'b0000);

    // Channel 0 release.
    btn_in[0] = 1'b0;
    p = cyc;
    push_exp(4'b0000, 4'b0001, 4'b0000, p + LoOff, p + HiOff);
    step(24);
    check(btn_db == 4'b0000, "ch0_level_lo", btn_db, 4'b0000);

    // Channel 1 bounce, then a clean press.
    for (int k = 0; k < 14; k++) begin
      btn_in[1] = ~btn_in[1];
      step(3);
    end
    check(btn_db == 4'b0000, "bounce_level", btn_db, 4'b0000);
    btn_in[1] = 1'b1;
    p = cyc;
    push_exp(4'b0010, 4'b0000, 4'b0010, p + LoOff, p + HiOff);
    step(24);
    check(btn_db == 4'b0010, "ch1_level_hi", btn_db, 4'b0010);
    btn_in[1] = 1'b0;
    p = cyc;
    push_exp(4'b0000, 4'b0010, 4'b0000, p + LoOff, p + HiOff);
    step(24);
    check(btn_db == 4'b0000, "ch1_level_lo", btn_db, 4'b0000);

    // Abort on the very tick that would have accepted channel 2.
    btn_in[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (busy[2] && tick) found = 1'b1;
    end
    check(found, "abort_first_tick", {31'd0, found}, 1);
    e_cyc = cyc;
    step(4);
    check(tick == 1'b1, "tick_period", {31'd0, tick}, 1);
    step(2);
    btn_in[2] = 1'b0;
    step(2);
    check(tick && busy[2], "abort_tick_cycle", {tick, busy}, {1'b1, 4'b0100});
    step(1);
    check(busy == 4'b0000, "abort_busy", busy, 4'b0000);
    check(btn_db == 4'b0000, "abort_level", btn_db, 4'b0000);
    step(20);

    // All channels together, with enable dropped after the first counted tick.
    btn_in = 4'b1111;
    found  = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if ((busy == 4'b1111) && tick) found = 1'b1;
    end
    check(found, "all_first_tick", {31'd0, found}, 1);
    step(1);
    enable  = 1'b0;
    held_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (tick || (busy != 4'b1111)) held_ok = 1'b0;
    end
    check(held_ok, "enable_hold", {tick, busy}, {1'b0, 4'b1111});
    enable = 1'b1;
    p = cyc;
    // Count froze at 1, so two more ticks accept; the first arrives TickCycles later.
    push_exp(4'b1111, 4'b0000, 4'b1111, p + 2 * TickCycles, p + 2 * TickCycles);
    step(14);
    check(btn_db == 4'b1111, "all_level_hi", btn_db, 4'b1111);

    // Reset in the middle of a channel 3 release check.
    btn_in = 4'b0111;
    step(5);
    check(busy == 4'b1000, "chk_lo_busy", busy, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    check({btn_db, rise, fall, busy, tick} == '0, "async_reset",
          {btn_db, rise, fall, busy, tick}, 0);
    btn_in = '0;
    step(2);
    reset = 1'b0;
    step(1);
    check({btn_db, rise, fall, busy, tick} == '0, "post_reset2",
          {btn_db, rise, fall, busy, tick}, 0);
    step(20);
    check((btn_db == '0) && (busy == '0), "stay_low", {btn_db, busy}, 0);
    btn_in[3] = 1'b1;
    p = cyc;
    push_exp(4'b1000, 4'b0000, 4'b1000, p + LoOff, p + HiOff);
    step(24);
    check(btn_db == 4'b1000, "ch3_level_hi", btn_db, 4'b1000);

    check(exp_q.size() == 0, "pending_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
